// File: rtl/sha3_sponge_ctrl.sv
// SHA3-512 sponge sequencer: clears the state, hands each 72-byte rate block
// to processInput, loads the absorbed state back, then steps the one-round-
// per-cycle Keccak-f[1600] datapath through every round. Repeats until the
// host has no more data, then flags the digest valid. Abort and absorb
// timeout both kill processInput and return to idle.
module sha3_sponge_ctrl #(
  parameter int unsigned ROUNDS  = 24,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             data_done,
  input  logic             pi_buffer_empty,
  input  logic             pi_done,
  output logic             pi_go,
  output logic             pi_kill,
  output logic             state_clr,
  output logic             state_ld_pi,
  output logic             round_en,
  output logic [4:0]       round_idx,
  output logic             busy,
  output logic             done,
  output logic             digest_valid,
  output logic             error,
  output logic [CNT_W-1:0] block_count
);

  // Timeout counter only ever holds 0..TIMEOUT-1.
  localparam int unsigned ToW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [4:0]     LastRound = 5'(ROUNDS - 1);
  localparam logic [ToW-1:0] LastWait  = ToW'(TIMEOUT - 1);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StClear   = 3'd1;
  localparam logic [2:0] StPiStart = 3'd2;
  localparam logic [2:0] StPiWait  = 3'd3;
  localparam logic [2:0] StRound   = 3'd4;
  localparam logic [2:0] StCheck   = 3'd5;
  localparam logic [2:0] StFinish  = 3'd6;

  logic [2:0]       state_q, state_d;
  logic [4:0]       rnd_q, rnd_d;
  logic [ToW-1:0]   to_q, to_d;
  logic             dd_q, dd_d;
  logic [CNT_W-1:0] blk_q, blk_d;
  logic             err_q, err_d;
  logic             dv_q, dv_d;
  logic             kill_q, kill_d;
  logic             abortable;

  // States in which abort is honoured; FINISH deliberately excluded so a
  // completed digest is never thrown away.
  always_comb begin
    abortable = (state_q == StClear) || (state_q == StPiStart) ||
                (state_q == StPiWait) || (state_q == StRound) ||
                (state_q == StCheck);
  end

  // Next-state and sticky status logic.
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    to_d    = to_q;
    dd_d    = dd_q;
    blk_d   = blk_q;
    err_d   = err_q;
    dv_d    = dv_q;
    kill_d  = 1'b0;

    // Remember a data_done level or pulse seen at any point during the hash.
    if (state_q != StIdle && data_done) begin
      dd_d = 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (start && !abort) begin
          state_d = StClear;
          blk_d   = '0;
          err_d   = 1'b0;
          dv_d    = 1'b0;
          dd_d    = data_done;
        end
      end
      StClear: begin
        state_d = StPiStart;
      end
      StPiStart: begin
        to_d    = '0;
        state_d = StPiWait;
      end
      StPiWait: begin
        if (pi_done) begin
          state_d = StRound;
          rnd_d   = '0;
        end else if (to_q == LastWait) begin
          state_d = StIdle;
          kill_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          to_d = to_q + 1'b1;
        end
      end
      StRound: begin
        if (rnd_q == LastRound) begin
          state_d = StCheck;
          rnd_d   = '0;
        end else begin
          rnd_d = rnd_q + 5'd1;
        end
      end
      StCheck: begin
        // Saturate rather than wrap so a huge message never reports 0 blocks.
        blk_d = (&blk_q) ? blk_q : blk_q + CNT_W'(1);
        if (dd_q && pi_buffer_empty) begin
          state_d = StFinish;
        end else begin
          state_d = StPiStart;
        end
      end
      StFinish: begin
        dv_d    = 1'b1;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Abort overrides pi_done, round completion and the block increment.
    if (abort && abortable) begin
      state_d = StIdle;
      kill_d  = 1'b1;
      rnd_d   = '0;
      to_d    = to_q;
      blk_d   = blk_q;
      err_d   = err_q;
      dv_d    = dv_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      rnd_q   <= '0;
      to_q    <= '0;
      dd_q    <= 1'b0;
      blk_q   <= '0;
      err_q   <= 1'b0;
      dv_q    <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      to_q    <= to_d;
      dd_q    <= dd_d;
      blk_q   <= blk_d;
      err_q   <= err_d;
      dv_q    <= dv_d;
      kill_q  <= kill_d;
    end
  end

  // Datapath strobes decoded from state; at most one is high per cycle.
  always_comb begin
    state_clr    = (state_q == StClear);
    pi_go        = (state_q == StPiStart);
    state_ld_pi  = (state_q == StPiWait) && pi_done && !abort;
    round_en     = (state_q == StRound);
    round_idx    = (state_q == StRound) ? rnd_q : 5'd0;
    busy         = (state_q != StIdle);
    done         = (state_q == StFinish);
    pi_kill      = kill_q;
    digest_valid = dv_q;
    error        = err_q;
    block_count  = blk_q;
  end

endmodule

// File: tb/tb_sha3_sponge_ctrl.sv
// Bench for sha3_sponge_ctrl: models processInput and the host, and predicts
// every event time from the per-block latency rule.
module tb_sha3_sponge_ctrl;
  localparam int R  = 24;
  localparam int TO = 1023;
  localparam int CW = 16;

  logic clk = 1'b0;
  logic rst, start, abort, data_done, pi_buffer_empty, pi_done;
  logic pi_go, pi_kill, state_clr, state_ld_pi, round_en, busy, done, digest_valid, error;
  logic [4:0]    round_idx;
  logic [CW-1:0] block_count;

  sha3_sponge_ctrl #(.ROUNDS(R), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .data_done(data_done),
    .pi_buffer_empty(pi_buffer_empty), .pi_done(pi_done), .pi_go(pi_go), .pi_kill(pi_kill),
    .state_clr(state_clr), .state_ld_pi(state_ld_pi), .round_en(round_en),
    .round_idx(round_idx), .busy(busy), .done(done), .digest_valid(digest_valid),
    .error(error), .block_count(block_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Per-block pi_done latency in cycles after pi_go; 0 means never answer.
  int w_q[$];
  int sq[$], pq[$], cq[$];
  int pd_cnt, go_idx, ld_cnt, n_go, n_ren, n_done, n_kill, done_at, kill_at;
  int ridx_exp, v_ridx, v_onehot, v_idle_ridx, done_exp;
  logic err_c1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs_vec();
    return 32'({pi_go, pi_kill, state_clr, state_ld_pi, round_en, round_idx, busy, done,
                digest_valid, error, block_count});
  endfunction

  task automatic drive_idle();
    start = 1'b0; abort = 1'b0; data_done = 1'b0; pi_done = 1'b0; pi_buffer_empty = 1'b0;
  endtask

  // Reference schedule: PI_START, W wait cycles, R rounds, CHECK per block.
  task automatic ref_sched(input int n);
    int s;
    sq.delete(); pq.delete(); cq.delete();
    s = 2;
    for (int k = 0; k < n; k++) begin
      sq.push_back(s);
      pq.push_back(s + w_q[k]);
      cq.push_back(s + w_q[k] + R + 1);
      s = s + w_q[k] + R + 2;
    end
    done_exp = s;
  endtask

  task automatic sample(input int c);
    if (pi_go) begin
      n_go++;
      if (go_idx < w_q.size() && w_q[go_idx] > 0) pd_cnt = w_q[go_idx];
      go_idx++;
    end
    if (state_ld_pi) begin
      ld_cnt++;
      ridx_exp = 0;
    end
    if (round_en) begin
      n_ren++;
      if (round_idx !== 5'(ridx_exp)) v_ridx++;
      ridx_exp = (ridx_exp + 1) % R;
    end else if (round_idx !== 5'd0) begin
      v_idle_ridx++;
    end
    if (int'(pi_go) + int'(state_clr) + int'(state_ld_pi) + int'(round_en) > 1) v_onehot++;
    if (done === 1'b1) begin
      n_done++;
      if (done_at < 0) done_at = c;
    end
    if (pi_kill === 1'b1) begin
      n_kill++;
      if (kill_at < 0) kill_at = c;
    end
    if (c == 1) err_c1 = error;
  endtask

  // Starts a hash at cycle 0; runs until done/kill or budget, then 3 idle cycles.
  task automatic run_hash(input int n, input int abort_at, input int sb_at, input int dd_at,
                          input int budget);
    int c;
    pd_cnt = 0; go_idx = 0; ld_cnt = 0; n_go = 0; n_ren = 0; n_done = 0; n_kill = 0;
    done_at = -1; kill_at = -1; ridx_exp = 0; v_ridx = 0; v_onehot = 0; v_idle_ridx = 0;
    err_c1 = 1'bx;
    c = 0;
    while (c < budget) begin
      start = (c == 0) || (c == sb_at);
      abort = (c == abort_at);
      data_done = (c == dd_at);
      pi_done = 1'b0;
      if (pd_cnt > 0) begin
        pd_cnt--;
        if (pd_cnt == 0) pi_done = 1'b1;
      end
      pi_buffer_empty = (ld_cnt >= n);
      #1;
      sample(c);
      @(posedge clk); #1;
      c++;
      if (n_done > 0 || n_kill > 0) break;
    end
    for (int t = 0; t < 3; t++) begin
      drive_idle();
      #1;
      sample(c);
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic expect_ok(input string tag, input int n);
    ref_sched(n);
    chk({tag, "_done_at"}, done_at, done_exp);
    chk({tag, "_done_cnt"}, n_done, 1);
    chk({tag, "_pi_go_cnt"}, n_go, n);
    chk({tag, "_ld_cnt"}, ld_cnt, n);
    chk({tag, "_round_en_cnt"}, n_ren, n * R);
    chk({tag, "_kill_cnt"}, n_kill, 0);
    chk({tag, "_block_count"}, 32'(block_count), n);
    chk({tag, "_digest_valid"}, 32'(digest_valid), 1);
    chk({tag, "_busy_after"}, 32'(busy), 0);
    chk({tag, "_invariants"}, v_ridx + v_onehot + v_idle_ridx, 0);
  endtask

  task automatic expect_abort(input string tag, input int n, input int a);
    int bc, ld;
    ref_sched(n);
    bc = 0; ld = 0;
    for (int k = 0; k < n; k++) begin
      if (cq[k] < a) bc++;
      if (pq[k] < a) ld++;
    end
    chk({tag, "_kill_at"}, kill_at, a + 1);
    chk({tag, "_kill_cnt"}, n_kill, 1);
    chk({tag, "_done_cnt"}, n_done, 0);
    chk({tag, "_ld_cnt"}, ld_cnt, ld);
    chk({tag, "_block_count"}, 32'(block_count), bc);
    chk({tag, "_digest_valid"}, 32'(digest_valid), 0);
    chk({tag, "_busy_after"}, 32'(busy), 0);
    chk({tag, "_invariants"}, v_ridx + v_onehot + v_idle_ridx, 0);
  endtask

  initial begin
    byte unsigned msg[$];
    int n, a, len;
    drive_idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: idle after reset
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("reset_idle_outputs", outs_vec(), 32'd0);
      @(posedge clk); #1;
    end

    // 2: 100-byte message, two blocks
    for (int i = 0; i < 99; i++) msg.push_back(byte'((i % 11) + 1));
    msg.push_back(8'd15);
    n = msg.size() / 72 + 1;
    w_q = '{4, 4};
    run_hash(n, -1, -1, 1, 80);
    expect_ok("msg100", n);
    chk("msg100_done_62", done_at, 62);

    // 3: abort at round_idx 10 of block 1
    w_q = '{4, 4};
    a = 3 + 4 + 10;
    run_hash(2, a, -1, 1, a + 6);
    expect_abort("abort_round10", 2, a);

    // 4: absorb timeout, then last-chance pi_done and error clearing
    w_q = '{0};
    run_hash(1, -1, -1, 1, TO + 20);
    chk("timeout_kill_at", kill_at, 3 + TO);
    chk("timeout_kill_cnt", n_kill, 1);
    chk("timeout_error", 32'(error), 1);
    chk("timeout_no_done", n_done, 0);
    chk("timeout_busy", 32'(busy), 0);
    w_q = '{TO};
    run_hash(1, -1, -1, 1, TO + 60);
    chk("restart_error_cleared", 32'(err_c1), 0);
    expect_ok("wait_max", 1);
    chk("wait_max_error", 32'(error), 0);

    // 5a: start+abort in idle
    start = 1'b1; abort = 1'b1;
    #1;
    @(posedge clk); #1;
    drive_idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("start_abort_idle", 32'({busy, state_clr, pi_kill, digest_valid}), 32'd1);
      @(posedge clk); #1;
    end

    // 5b: pi_done and abort together on block 2
    w_q = '{5, 5};
    ref_sched(2);
    a = pq[1];
    run_hash(2, a, -1, 2, a + 6);
    expect_abort("pidone_abort", 2, a);

    // 5c: start while busy is ignored
    w_q = '{3};
    run_hash(1, -1, 10, 0, 60);
    expect_ok("start_busy", 1);

    // abort in CHECK holds block_count; abort in FINISH is ignored
    w_q = '{2, 2};
    ref_sched(2);
    a = cq[0];
    run_hash(2, a, -1, 1, a + 6);
    expect_abort("abort_check", 2, a);
    w_q = '{2};
    ref_sched(1);
    run_hash(1, done_exp, -1, 1, done_exp + 6);
    expect_ok("abort_finish", 1);

    // 6: reset in PI_WAIT, then a fresh one-block hash
    w_q = '{0};
    run_hash(1, -1, -1, 1, 5);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("reset_mid_wait", outs_vec(), 32'd0);
    @(posedge clk); #1;
    chk("reset_mid_wait_no_kill", 32'(pi_kill), 0);
    w_q = '{3};
    run_hash(1, -1, -1, 3, 60);
    expect_ok("after_reset", 1);

    // randomized messages, latencies and aborts
    for (int i = 0; i < 8; i++) begin
      len = int'($urandom_range(0, 220));
      n = len / 72 + 1;
      w_q.delete();
      for (int k = 0; k < n; k++) w_q.push_back(int'($urandom_range(1, 8)));
      ref_sched(n);
      if ($urandom_range(0, 1) == 1) begin
        a = int'($urandom_range(1, cq[n-1]));
        run_hash(n, a, -1, int'($urandom_range(0, 3)), a + 6);
        expect_abort($sformatf("rand%0d_abort", i), n, a);
      end else begin
        run_hash(n, -1, -1, int'($urandom_range(0, 3)), done_exp + 6);
        expect_ok($sformatf("rand%0d", i), n);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
